// File: rtl/pipelined_hybrid_adder.sv
// Pipelined WIDTH-bit add/subtract: one 4-bit segment per stage, CLA cells on even stages,
// Kogge-Stone cells on odd stages. Define HYBRID_ADD_OVF_EN to produce the signed-overflow flag.
module pipelined_hybrid_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSEG = WIDTH / SEG;

    if (SEG != 4 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("pipelined_hybrid_adder: SEG must be 4 and WIDTH a non-zero multiple of SEG");
    end

    // Returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [3:0] g, p;
        logic [4:0] cv;
        g     = x & y;
        p     = x ^ y;
        cv[0] = c;
        cv[1] = g[0] | (p[0] & c);
        cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        cv[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c);
        return {cv[4], p ^ cv[3:0]};
    endfunction

    // Carry-in is folded into bit 0's generate, so two prefix levels cover all four carries.
    function automatic logic [4:0] ksa4(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [3:0] g, p, g1, p1, g2;
        g     = x & y;
        p     = x ^ y;
        g1[0] = g[0] | (p[0] & c);
        p1[0] = 1'b0;
        g1[1] = g[1] | (p[1] & g1[0]);
        p1[1] = 1'b0;
        g1[2] = g[2] | (p[2] & g[1]);
        p1[2] = p[2] & p[1];
        g1[3] = g[3] | (p[3] & g[2]);
        p1[3] = p[3] & p[2];
        g2[0] = g1[0];
        g2[1] = g1[1];
        g2[2] = g1[2] | (p1[2] & g1[0]);
        g2[3] = g1[3] | (p1[3] & g1[1]) | (p1[0] & p1[1]);
        return {g2[3], p ^ {g2[2:0], c}};
    endfunction

    logic             w_adv;
    logic             w_acc;
    logic [WIDTH-1:0] w_bx;
    logic             w_c0;

    logic [WIDTH-1:0] r_sum [NSEG];
    logic [WIDTH-1:0] r_opa [NSEG];
    logic [WIDTH-1:0] r_opb [NSEG];
    logic             r_c   [NSEG];
    logic             r_vld [NSEG];

    logic [SEG-1:0]   w_sa  [NSEG];
    logic [SEG-1:0]   w_sb  [NSEG];
    logic             w_ci  [NSEG];
    logic             w_vin [NSEG];
    logic [SEG:0]     w_res [NSEG];

    assign w_adv    = !r_vld[NSEG-1] | out_ready;
    assign in_ready = w_adv;
    assign w_acc    = in_valid & w_adv;
    assign w_bx     = b ^ {WIDTH{sub}};
    assign w_c0     = sub | cin;

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign w_sa[gi]  = a[SEG-1:0];
            assign w_sb[gi]  = w_bx[SEG-1:0];
            assign w_ci[gi]  = w_c0;
            assign w_vin[gi] = w_acc;
        end else begin : g_rest
            assign w_sa[gi]  = r_opa[gi-1][SEG-1:0];
            assign w_sb[gi]  = r_opb[gi-1][SEG-1:0];
            assign w_ci[gi]  = r_c[gi-1];
            assign w_vin[gi] = r_vld[gi-1];
        end
        if (gi % 2 == 0) begin : g_cla
            assign w_res[gi] = cla4(w_sa[gi], w_sb[gi], w_ci[gi]);
        end else begin : g_ksa
            assign w_res[gi] = ksa4(w_sa[gi], w_sb[gi], w_ci[gi]);
        end
    end

    // Sum bits enter at the top and shift down one segment per stage; operands shift the
    // next unprocessed segment into bits [3:0]. Data registers only load on a valid slot so
    // the output holds its last result across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                r_sum[k] <= '0;
                r_opa[k] <= '0;
                r_opb[k] <= '0;
                r_c[k]   <= 1'b0;
                r_vld[k] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < NSEG; k++) begin
                r_vld[k] <= w_vin[k];
            end
            if (w_acc) begin
                r_sum[0] <= WIDTH'(w_res[0][SEG-1:0]) << (WIDTH - SEG);
                r_c[0]   <= w_res[0][SEG];
                if (NSEG > 1) begin
                    r_opa[0] <= a >> SEG;
                    r_opb[0] <= w_bx >> SEG;
                end
            end
            for (int k = 1; k < NSEG; k++) begin
                if (w_vin[k]) begin
                    r_sum[k] <= (r_sum[k-1] >> SEG) | (WIDTH'(w_res[k][SEG-1:0]) << (WIDTH - SEG));
                    r_c[k]   <= w_res[k][SEG];
                    if (k < NSEG - 1) begin
                        r_opa[k] <= r_opa[k-1] >> SEG;
                        r_opb[k] <= r_opb[k-1] >> SEG;
                    end
                end
            end
        end
    end

    assign out_valid = r_vld[NSEG-1];
    assign sum       = r_sum[NSEG-1];
    assign cout      = r_c[NSEG-1];

`ifdef HYBRID_ADD_OVF_EN
    logic r_ovf;
    logic w_ovf_next;
    // The final stage's operand segment holds the operand MSBs, so no extra skew flops are needed.
    assign w_ovf_next = (w_sa[NSEG-1][SEG-1] ~^ w_sb[NSEG-1][SEG-1])
                      & (w_res[NSEG-1][SEG-1] ^ w_sa[NSEG-1][SEG-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_adv && w_vin[NSEG-1]) begin
            r_ovf <= w_ovf_next;
        end
    end
    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_hybrid_adder.sv
// Scoreboard bench for pipelined_hybrid_adder: driver pushes model results on accept,
// a negedge monitor pops and compares on every output handshake.
module tb_pipelined_hybrid_adder;
    parameter int WIDTH = 16;
    localparam int NSEG = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rdy_mode = 0;
    bit   lat_chk  = 0;

    pipelined_hybrid_adder #(.WIDTH(WIDTH), .SEG(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as numbers.
    function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                   input logic tcin, input logic tsub);
        exp_t         r;
        logic [WIDTH:0] full;
        longint       sa, sbv, sres;
        sa  = longint'($signed(ta));
        sbv = longint'($signed(tb_));
        if (tsub) begin
            r.sum  = ta - tb_;
            r.cout = (ta >= tb_);
            sres   = sa - sbv;
        end else begin
            full   = {1'b0, ta} + {1'b0, tb_} + {{WIDTH{1'b0}}, tcin};
            r.sum  = full[WIDTH-1:0];
            r.cout = full[WIDTH];
            sres   = sa + sbv + longint'(tcin);
        end
`ifdef HYBRID_ADD_OVF_EN
        r.ovf = (sres > (longint'(1) <<< (WIDTH - 1)) - 1) || (sres < -(longint'(1) <<< (WIDTH - 1)));
`else
        r.ovf = (sres != sres);
`endif
        r.acc = 0;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 3 == 0);
            2: out_ready = 1'($urandom);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: handshake checks, hold-while-stalled checks, in_ready relation.
    initial begin : monitor
        bit               hold_pend;
        logic [WIDTH-1:0] hold_sum;
        logic             hold_cout, hold_ovf;
        exp_t             e;
        hold_pend = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 0;
            end else begin
                check("in_ready", in_ready, !out_valid || out_ready);
                if (hold_pend && out_valid) begin
                    check("hold_sum", sum, hold_sum);
                    check("hold_cout", cout, hold_cout);
                    check("hold_ovf", ovf, hold_ovf);
                end
                hold_pend = 0;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        $display("[TB] result sum=0x%0h cout=%0d ovf=%0d (cycle %0d)", sum, cout, ovf, cyc);
                        check("sum", sum, e.sum);
                        check("cout", cout, e.cout);
                        check("ovf", ovf, e.ovf);
                        if (lat_chk) check("latency", cyc - e.acc, NSEG);
                    end
                end else if (out_valid) begin
                    hold_pend = 1;
                    hold_sum  = sum;
                    hold_cout = cout;
                    hold_ovf  = ovf;
                end
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tcin, input logic tsub);
        bit   done;
        int   k;
        exp_t e;
        done = 0;
        k    = 0;
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e     = model(ta, tb_, tcin, tsub);
                e.acc = cyc;
                sb_q.push_back(e);
                done  = 1;
            end
            @(posedge clk);
            #1;
            k++;
            if (!done && k >= 100) begin
                check("issue_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        check("drain_pending", sb_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n_rst_ops;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed vectors with fixed latency checking.
        lat_chk = 1;
        issue(WIDTH'(16'hFFFF), WIDTH'(16'h0001), 1'b0, 1'b0);
        issue(WIDTH'(16'h0005), WIDTH'(16'h0007), 1'b0, 1'b1);
        issue(WIDTH'(16'h0007), WIDTH'(16'h0005), 1'b0, 1'b1);
        issue({1'b0, {(WIDTH-1){1'b1}}}, WIDTH'(1), 1'b0, 1'b0);
        issue({1'b1, {(WIDTH-1){1'b0}}}, WIDTH'(1), 1'b0, 1'b1);
        issue(WIDTH'(1), WIDTH'(1), 1'b0, 1'b0);
        issue({1'b0, {(WIDTH-1){1'b1}}}, '0, 1'b1, 1'b0);
        issue('1, '1, 1'b1, 1'b0);
        drain();
        lat_chk = 0;

        // Back-to-back stream with out_ready pattern 1,0,0.
        rdy_mode = 1;
        for (int i = 0; i < 8; i++)
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
        drain();

        // Random mix with gaps, garbage operands while idle, random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
                @(posedge clk);
                #1;
            end
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();

        // Reset mid-flight: stalled results must vanish.
        rdy_mode  = 3;
        n_rst_ops = (NSEG >= 3) ? 3 : NSEG;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < n_rst_ops; i++)
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        repeat (NSEG) @(posedge clk);
        #1;
        check("stall_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (NSEG + 3) @(posedge clk);
        #1;
        check("post_rst_idle", out_valid, 0);
        lat_chk = 1;
        issue(WIDTH'(16'h1234), WIDTH'(16'h0FED), 1'b1, 1'b0);
        drain();
        lat_chk = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
